// File: rtl/sine_nco_pkg.sv
// Shared types and helpers for the sine NCO sequencer.
// Holds the FSM state enum, the fold result struct, the QUARTER constant,
// the default widths and the quadrant-fold function.
package sine_nco_pkg;

    localparam int unsigned DEF_PHASE_W = 16;
    localparam int unsigned DEF_DATA_W  = 16;

    localparam logic [DEF_PHASE_W-1:0] QUARTER = 16'h4000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ISSUE_C,
        ST_WAIT_C,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic [DEF_PHASE_W-1:0] angle;
        logic                   neg;
    } fold_t;

    // Map a full-circle phase onto 0..QUARTER plus a negate flag for the lower half-plane.
    function automatic fold_t fold(input logic [DEF_PHASE_W-1:0] phase);
        fold_t f;
        f.neg = phase[DEF_PHASE_W-1];
        if (phase[DEF_PHASE_W-2]) begin
            f.angle = QUARTER - {2'b00, phase[DEF_PHASE_W-3:0]};
        end else begin
            f.angle = {2'b00, phase[DEF_PHASE_W-3:0]};
        end
        return f;
    endfunction

endpackage

// File: rtl/phase_folder.sv
// Combinational quadrant fold of a 16-bit binary phase.
// Ports:
//   phase    in   phase, 0x10000 = 360 deg
//   angle_c  out  folded angle 0..0x4000
//   neg_c    out  result must be negated (phase in 180..360 deg)
module phase_folder
    import sine_nco_pkg::*;
(
    input  logic [DEF_PHASE_W-1:0] phase,
    output logic [DEF_PHASE_W-1:0] angle_c,
    output logic                   neg_c
);

    fold_t f;

    assign f       = fold(phase);
    assign angle_c = f.angle;
    assign neg_c   = f.neg;

endmodule

// File: rtl/sine_nco_sequencer.sv
// Phase-accumulator front end and result collector for the CORDIC sine core.
// Advances a binary phase, issues one folded-angle transaction per sample to
// the core, sign-corrects the result and presents it on a valid/ready stream.
// Optional build macro: NCO_COSINE_EN adds Cos_o and a second core
// transaction per sample at phase + 90 deg.
// Ports:
//   Clk_i, Rst_i           clock, synchronous active-low reset
//   En_i                   run enable (level)
//   FreqWord_i             phase increment, applied when a sample is accepted
//   PhaseLoad_i/Init_i     phase load, honoured only while idle
//   CoreStart_o/Angle_o    request to the sine core
//   CoreSine_i/Done_i      result from the sine core
//   Sample_o/Valid_o/Ready_i  output sample stream
//   Busy_o                 FSM not idle
//   Err_o                  sticky core timeout flag
module sine_nco_sequencer
    import sine_nco_pkg::*;
#(
    parameter int unsigned PHASE_W        = DEF_PHASE_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               Clk_i,
    input  logic               Rst_i,
    input  logic               En_i,
    input  logic [PHASE_W-1:0] FreqWord_i,
    input  logic               PhaseLoad_i,
    input  logic [PHASE_W-1:0] PhaseInit_i,
    output logic               CoreStart_o,
    output logic [PHASE_W-1:0] CoreAngle_o,
    input  logic [DATA_W-1:0]  CoreSine_i,
    input  logic               CoreDone_i,
    output logic [DATA_W-1:0]  Sample_o,
    output logic               SampleValid_o,
    input  logic               SampleReady_i,
    output logic               Busy_o,
`ifdef NCO_COSINE_EN
    output logic [DATA_W-1:0]  Cos_o,
`endif
    output logic               Err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;

    logic               start_d;
    logic [PHASE_W-1:0] angle_d;
    logic [DATA_W-1:0]  sample_d;
    logic               valid_d;
    logic               busy_d;
    logic               err_d;
    logic [DATA_W-1:0]  fixed_c;

    logic [PHASE_W-1:0] sin_angle_c;
    logic               sin_neg_c;

    // Fold is taken on the phase that will be live at the next edge, so a
    // back-to-back issue after accept already sees the advanced phase.
    phase_folder u_sin_fold (
        .phase   (phase_d),
        .angle_c (sin_angle_c),
        .neg_c   (sin_neg_c)
    );

`ifdef NCO_COSINE_EN
    logic [PHASE_W-1:0] cos_phase;
    logic [PHASE_W-1:0] cos_angle_c;
    logic               cos_neg_c;
    logic [DATA_W-1:0]  cos_d;

    assign cos_phase = phase_q + QUARTER;

    phase_folder u_cos_fold (
        .phase   (cos_phase),
        .angle_c (cos_angle_c),
        .neg_c   (cos_neg_c)
    );
`endif

    // Core output is non-negative and <= 0x7FFF, so negation cannot overflow.
    assign fixed_c = neg_q ? (~CoreSine_i + DATA_W'(1)) : CoreSine_i;

    // Phase next-value: load only while idle, advance only on accept.
    always_comb begin
        phase_d = phase_q;
        if (state_q == ST_IDLE && PhaseLoad_i) begin
            phase_d = PhaseInit_i;
        end else if (state_q == ST_OUT && SampleValid_o && SampleReady_i) begin
            phase_d = phase_q + FreqWord_i;
        end
    end

    // Next-state and registered-output next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        start_d  = 1'b0;
        angle_d  = CoreAngle_o;
        sample_d = Sample_o;
        valid_d  = SampleValid_o;
        err_d    = Err_o;
`ifdef NCO_COSINE_EN
        cos_d    = Cos_o;
`endif
        case (state_q)
            ST_IDLE: begin
                if (En_i) begin
                    state_d = ST_ISSUE;
                    start_d = 1'b1;
                    angle_d = sin_angle_c;
                    neg_d   = sin_neg_c;
                end
            end
            ST_ISSUE: begin
                // Counter holds cycles elapsed since the start pulse.
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(1);
            end
            ST_WAIT: begin
                if (CoreDone_i) begin
                    sample_d = fixed_c;
`ifdef NCO_COSINE_EN
                    state_d  = ST_ISSUE_C;
                    start_d  = 1'b1;
                    angle_d  = cos_angle_c;
                    neg_d    = cos_neg_c;
`else
                    state_d  = ST_OUT;
                    valid_d  = 1'b1;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef NCO_COSINE_EN
            ST_ISSUE_C: begin
                state_d = ST_WAIT_C;
                cnt_d   = CNT_W'(1);
            end
            ST_WAIT_C: begin
                if (CoreDone_i) begin
                    cos_d   = fixed_c;
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_OUT: begin
                if (SampleReady_i) begin
                    valid_d = 1'b0;
                    if (En_i) begin
                        state_d = ST_ISSUE;
                        start_d = 1'b1;
                        angle_d = sin_angle_c;
                        neg_d   = sin_neg_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State register.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            phase_q       <= '0;
            cnt_q         <= '0;
            neg_q         <= 1'b0;
            CoreStart_o   <= 1'b0;
            CoreAngle_o   <= '0;
            Sample_o      <= '0;
            SampleValid_o <= 1'b0;
            Busy_o        <= 1'b0;
            Err_o         <= 1'b0;
`ifdef NCO_COSINE_EN
            Cos_o         <= '0;
`endif
        end else begin
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            neg_q         <= neg_d;
            CoreStart_o   <= start_d;
            CoreAngle_o   <= angle_d;
            Sample_o      <= sample_d;
            SampleValid_o <= valid_d;
            Busy_o        <= busy_d;
            Err_o         <= err_d;
`ifdef NCO_COSINE_EN
            Cos_o         <= cos_d;
`endif
        end
    end

endmodule

// File: tb/tb_sine_nco_sequencer.sv
`timescale 1ns/1ps
module tb_sine_nco_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, en, pload, ready;
    logic [15:0] freq, pinit;
    logic        core_done = 1'b0;
    logic [15:0] core_sine = 16'h0000;
    logic        start, valid, busy, err;
    logic [15:0] angle, sample;

    always #5 clk = ~clk;

    sine_nco_sequencer dut (
        .Clk_i         (clk),
        .Rst_i         (rst_n),
        .En_i          (en),
        .FreqWord_i    (freq),
        .PhaseLoad_i   (pload),
        .PhaseInit_i   (pinit),
        .CoreStart_o   (start),
        .CoreAngle_o   (angle),
        .CoreSine_i    (core_sine),
        .CoreDone_i    (core_done),
        .Sample_o      (sample),
        .SampleValid_o (valid),
        .SampleReady_i (ready),
        .Busy_o        (busy),
        .Err_o         (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d +-%0d (cycle %0d)", name, act, exp, tol, cyc);
        end
    endtask

    // Ideal quarter-wave sine: angle 0..16384 maps to 0..90 deg, Q1.15, clamped to 0x7FFF.
    function automatic int core_sin(input int a);
        real v;
        int  r;
        v = $sin(real'(a) * 3.14159265358979 / 32768.0) * 32768.0;
        r = $rtoi(v + 0.5);
        if (r > 32767) r = 32767;
        return r;
    endfunction

    // Reference: reflect into the first quadrant by quadrant number.
    function automatic int exp_angle(input int p);
        int q, off;
        q   = p / 16384;
        off = p % 16384;
        return (q % 2 == 1) ? 16384 - off : off;
    endfunction

    // Reference: sine of the full phase as a 16-bit two's complement pattern.
    function automatic int exp_sample(input int p);
        int s;
        s = core_sin(exp_angle(p));
        return (p >= 32768) ? (65536 - s) % 65536 : s;
    endfunction

    // Behavioural core: result and done 5 cycles after the start pulse.
    bit core_mute = 1'b0;
    int cd = -1;
    int core_a = 0;
    always @(negedge clk) begin
        core_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                core_done = 1'b1;
                core_sine = 16'(core_sin(core_a));
                cd = -1;
            end
        end
        if (start && !core_mute) begin
            cd = 5;
            core_a = int'(angle);
        end
    end

    // Scoreboard state.
    int          model_phase = 0;
    bit          rst_at_edge = 1'b0;
    bit          prev_start  = 1'b0;
    bit          prev_valid  = 1'b0;
    int          start_cycs[$];
    int          valid_cycs[$];
    logic [15:0] obs_angles[$];
    logic [15:0] obs_samples[$];

    always @(posedge clk) rst_at_edge <= rst_n;

    // Compare process: every cycle, against the model phase.
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            check("reset_ctl", {28'b0, start, valid, busy, err}, 0);
            check("reset_data", {angle, sample}, 0);
            model_phase = 0;
            prev_start  = 1'b0;
            prev_valid  = 1'b0;
        end else begin
            if (start) begin
                check("angle", int'(angle), exp_angle(model_phase));
                check("start_one_cycle", int'(prev_start), 0);
                check("start_while_valid", int'(valid), 0);
                start_cycs.push_back(cyc);
                obs_angles.push_back(angle);
            end
            if (valid) begin
                check("sample", int'(sample), exp_sample(model_phase));
                if (!prev_valid) valid_cycs.push_back(cyc);
                if (ready) begin
                    obs_samples.push_back(sample);
                    model_phase = (model_phase + int'(freq)) % 65536;
                end
            end
            prev_start = start;
            prev_valid = valid && !ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic load(input logic [15:0] v);
        pinit = v;
        pload = 1'b1;
        tick();
        pload = 1'b0;
        model_phase = int'(v);
    endtask

    task automatic run_one(input string name);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int abase, sbase, vbase, en_cyc, n, s_cyc, err_cyc;
        logic [15:0] held;
        bit seen_valid;

        rst_n = 1'b0; en = 1'b0; pload = 1'b0; ready = 1'b1;
        freq = 16'h0000; pinit = 16'h0000;
        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_err", int'(err), 0);
        rst_n = 1'b1;
        tick();

        // Sweep from phase 0 in steps of 30 deg.
        freq  = 16'd5461;
        abase = obs_angles.size();
        sbase = obs_samples.size();
        vbase = valid_cycs.size();
        en_cyc = cyc;
        en = 1'b1;
        n = 0;
        while (obs_angles.size() < abase + 4 && n < 100) begin
            tick();
            n++;
        end
        en = 1'b0;
        wait_idle("sweep_idle");
        check("sweep_count", obs_samples.size() - sbase, 4);
        if (obs_samples.size() >= sbase + 4 && start_cycs.size() >= abase + 4) begin
            check("sweep_angle0", int'(obs_angles[abase]),     16'h0000);
            check("sweep_angle1", int'(obs_angles[abase + 1]), 16'h1555);
            check("sweep_angle2", int'(obs_angles[abase + 2]), 16'h2AAA);
            check("sweep_angle3", int'(obs_angles[abase + 3]), 16'h3FFF);
            check("sweep_sample0", int'(obs_samples[sbase]), 16'h0000);
            check_near("sweep_sample1", int'(obs_samples[sbase + 1]), 16'h4000, 4);
            check_near("sweep_sample2", int'(obs_samples[sbase + 2]), 16'h6ED9, 8);
            check("sweep_sample3", int'(obs_samples[sbase + 3]), 16'h7FFF);
            check("en_to_start", start_cycs[abase] - en_cyc, 1);
            check("done_to_valid", valid_cycs[vbase] - start_cycs[abase], 6);
            check("back_to_back", start_cycs[abase + 1] - start_cycs[abase], 7);
        end

        // Phase loads into quadrants 1 and 3.
        load(16'h5555);
        run_one("load120_idle");
        check("load120_angle", int'(obs_angles[obs_angles.size() - 1]), 16'h2AAB);
        check_near("load120_sample", int'(obs_samples[obs_samples.size() - 1]), 16'h6ED9, 8);
        load(16'hC000);
        run_one("load270_idle");
        check("load270_angle", int'(obs_angles[obs_angles.size() - 1]), 16'h4000);
        check("load270_sample", int'(obs_samples[obs_samples.size() - 1]), 16'h8001);

        // Back-pressure: output held, ignored load, FreqWord taken at accept.
        load(16'h1000);
        freq  = 16'h0800;
        ready = 1'b0;
        en    = 1'b1;
        tick();
        en = 1'b0;
        n = 0;
        while (!valid && n < 30) begin
            tick();
            n++;
        end
        check("stall_valid_seen", int'(valid), 1);
        held  = sample;
        pinit = 16'h7777;
        for (int i = 0; i < 10; i++) begin
            pload = (i == 3);
            if (i == 5) freq = 16'h0400;
            tick();
            check("stall_valid", int'(valid), 1);
            check("stall_sample", int'(sample), int'(held));
            check("stall_no_start", int'(start), 0);
        end
        pload = 1'b0;
        ready = 1'b1;
        wait_idle("stall_idle");
        run_one("stall_next_idle");
        check("stall_next_angle", int'(obs_angles[obs_angles.size() - 1]), 16'h1400);

        // Wrap through 0x10000.
        load(16'hFFFF);
        freq = 16'd2;
        run_one("wrap_a_idle");
        check("wrap_a_angle", int'(obs_angles[obs_angles.size() - 1]), 16'h0001);
        check("wrap_a_sample", int'(obs_samples[obs_samples.size() - 1]), 16'hFFFD);
        run_one("wrap_b_idle");
        check("wrap_b_angle", int'(obs_angles[obs_angles.size() - 1]), 16'h0001);
        check_near("wrap_b_sample", int'(obs_samples[obs_samples.size() - 1]), 3, 1);

        // Core never answers: timeout after 64 cycles, phase untouched.
        core_mute = 1'b1;
        en = 1'b1;
        tick();
        en = 1'b0;
        check("to_start", int'(start), 1);
        s_cyc = cyc;
        err_cyc = -1;
        seen_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (err) begin
                err_cyc = cyc;
                break;
            end
            if (valid) seen_valid = 1'b1;
            tick();
        end
        check("to_err_delay", err_cyc - s_cyc, 64);
        check("to_busy", int'(busy), 0);
        check("to_no_valid", int'(seen_valid), 0);
        core_mute = 1'b0;
        run_one("to_retry_idle");
        check("to_phase_kept", int'(obs_angles[obs_angles.size() - 1]), 16'h0003);
        check("to_err_sticky", int'(err), 1);

        // Reset in WAIT: outputs cleared, late done ignored, phase back to 0.
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_wait_err", int'(err), 0);
        check("rst_wait_busy", int'(busy), 0);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid || start) seen_valid = 1'b1;
        end
        check("rst_late_done", int'(seen_valid), 0);
        run_one("rst_after_idle");
        check("rst_phase_zero", int'(obs_angles[obs_angles.size() - 1]), 16'h0000);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
